// File: rtl/bus_controller_if.sv
// Command, strobe and read-back signals between a host and bus_controller.
// The shared data bus itself stays a plain inout port on the controller.
interface bus_controller_if #(
    parameter int p_data_width = 8,
    parameter int p_num_regs   = 4,
    parameter int p_addr_width = 2
);
    logic                    i_w_valid;
    logic                    o_w_ready;
    logic [1:0]              i_w_op;
    logic [p_addr_width-1:0] i_w_src;
    logic [p_addr_width-1:0] i_w_dst;
    logic [p_data_width-1:0] i_w_imm;
    logic [p_num_regs-1:0]   o_w_we;
    logic [p_num_regs-1:0]   o_w_oe;
    logic [p_data_width-1:0] o_w_rd_data;
    logic                    o_w_rd_valid;
    logic                    o_w_error;

    modport slave (
        input  i_w_valid, i_w_op, i_w_src, i_w_dst, i_w_imm,
        output o_w_ready, o_w_we, o_w_oe, o_w_rd_data, o_w_rd_valid, o_w_error
    );

    modport master (
        output i_w_valid, i_w_op, i_w_src, i_w_dst, i_w_imm,
        input  o_w_ready, o_w_we, o_w_oe, o_w_rd_data, o_w_rd_valid, o_w_error
    );
endinterface

// File: rtl/bus_controller.sv
// Sequencer for a shared tri-state register bus: MOVE / LOAD / READ with a turnaround cycle.
// Optional BUS_CONTROLLER_READBACK_EN adds a VERIFY read-back after every LOAD.
//
// state  | meaning
// IDLE   | ready; validate and accept a command
// EXEC   | strobes and bus driver active for one cycle
// TURN   | all drivers released for one cycle
// VERIFY | (readback) oe[dst] asserted, bus compared to immediate
// TURN2  | (readback) release after VERIFY, error pulse on mismatch
module bus_controller #(
    parameter int p_data_width = 8,
    parameter int p_num_regs   = 4,
    parameter int p_addr_width = 2
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    bus_controller_if.slave         cmd_if,
    inout  wire  [p_data_width-1:0] io_w_bus
);
    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [p_num_regs-1:0] ONE_HOT0 = {{(p_num_regs-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_TURN
`ifdef BUS_CONTROLLER_READBACK_EN
        , S_VERIFY
        , S_TURN2
`endif
    } state_t;

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [p_data_width-1:0] imm_q;
    logic [p_num_regs-1:0]   we_q, oe_q;
    logic                    drive_q;
    logic [p_data_width-1:0] rd_data_q;
    logic                    rd_valid_q;
    logic                    error_q;
`ifdef BUS_CONTROLLER_READBACK_EN
    logic [p_addr_width-1:0] dst_q;
`endif

    logic                    src_oor, dst_oor, legal_d, drive_d;
    logic [p_num_regs-1:0]   we_d, oe_d;

    always_comb begin
        src_oor = int'(cmd_if.i_w_src) >= p_num_regs;
        dst_oor = int'(cmd_if.i_w_dst) >= p_num_regs;
        legal_d = 1'b0;
        we_d    = '0;
        oe_d    = '0;
        drive_d = 1'b0;
        case (cmd_if.i_w_op)
            OP_MOVE: begin
                legal_d = !src_oor && !dst_oor && (cmd_if.i_w_src != cmd_if.i_w_dst);
                we_d    = ONE_HOT0 << cmd_if.i_w_dst;
                oe_d    = ONE_HOT0 << cmd_if.i_w_src;
            end
            OP_LOAD: begin
                legal_d = !dst_oor;
                we_d    = ONE_HOT0 << cmd_if.i_w_dst;
                drive_d = 1'b1;
            end
            OP_READ: begin
                legal_d = !src_oor;
                oe_d    = ONE_HOT0 << cmd_if.i_w_src;
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MOVE;
            imm_q      <= '0;
            we_q       <= '0;
            oe_q       <= '0;
            drive_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
`ifdef BUS_CONTROLLER_READBACK_EN
            dst_q      <= '0;
`endif
        end else begin
            // Strobes and pulses default low so every active cycle is an explicit one-cycle set.
            we_q       <= '0;
            oe_q       <= '0;
            drive_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_if.i_w_valid) begin
                        if (legal_d) begin
                            op_q    <= cmd_if.i_w_op;
                            imm_q   <= cmd_if.i_w_imm;
                            we_q    <= we_d;
                            oe_q    <= oe_d;
                            drive_q <= drive_d;
                            state_q <= S_EXEC;
`ifdef BUS_CONTROLLER_READBACK_EN
                            dst_q   <= cmd_if.i_w_dst;
`endif
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_READ) begin
                        rd_data_q  <= io_w_bus;
                        rd_valid_q <= 1'b1;
                    end
                    state_q <= S_TURN;
                end
                S_TURN: begin
`ifdef BUS_CONTROLLER_READBACK_EN
                    if (op_q == OP_LOAD) begin
                        oe_q    <= ONE_HOT0 << dst_q;
                        state_q <= S_VERIFY;
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef BUS_CONTROLLER_READBACK_EN
                S_VERIFY: begin
                    if (io_w_bus != imm_q) error_q <= 1'b1;
                    state_q <= S_TURN2;
                end
                S_TURN2: state_q <= S_IDLE;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_w_bus            = drive_q ? imm_q : 'z;
    assign cmd_if.o_w_ready    = (state_q == S_IDLE);
    assign cmd_if.o_w_we       = we_q;
    assign cmd_if.o_w_oe       = oe_q;
    assign cmd_if.o_w_rd_data  = rd_data_q;
    assign cmd_if.o_w_rd_valid = rd_valid_q;
    assign cmd_if.o_w_error    = error_q;
endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: register bank model on the tri-state bus,
// directed scenarios plus randomized commands against a behavioural register-file model.
module tb_bus_controller;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 3;
`ifdef BUS_CONTROLLER_READBACK_EN
    localparam int LOAD_GAP = 5;
`else
    localparam int LOAD_GAP = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wire [DW-1:0] bus_w;
    bus_controller_if #(.p_data_width(DW), .p_num_regs(NR), .p_addr_width(AW)) bif ();
    bus_controller #(.p_data_width(DW), .p_num_regs(NR), .p_addr_width(AW)) dut (
        .i_w_clk  (clk),
        .i_w_reset(rst_n),
        .cmd_if   (bif),
        .io_w_bus (bus_w)
    );

    // Attached register bank
    logic [DW-1:0] regs [NR];
    logic seed, ignore_we;
    for (genvar g = 0; g < NR; g++) begin : g_reg
        assign bus_w = (bif.o_w_oe[g] & ~bif.o_w_we[g]) ? regs[g] : 'z;
    end
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (seed) regs[i] <= DW'(8'h20 + i * 8'h13);
            else if (bif.o_w_we[i] & ~bif.o_w_oe[i] & ~ignore_we) regs[i] <= bus_w;
        end
    end

    // Behavioural model: expected register contents and last read value
    logic [DW-1:0] mdl [NR];
    logic [DW-1:0] last_rd;
    int cyc = 0;
    int last_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("we_popcount", 32'($countones(bif.o_w_we) <= 1), 1);
            check("oe_popcount", 32'($countones(bif.o_w_oe) <= 1), 1);
            check("no_contention", 32'(dut.drive_q & (|bif.o_w_oe)), 0);
        end
    end

    task automatic do_cmd(input logic [1:0] op, input int src, input int dst,
                          input logic [DW-1:0] imm, input bit hold, input int exp_gap);
        bit legal;
        logic [NR-1:0] exp_we, exp_oe;
        logic [DW-1:0] exp_bus;
        int w;
        legal = (op == 2'd0) ? (src < NR && dst < NR && src != dst) :
                (op == 2'd1) ? (dst < NR) :
                (op == 2'd2) ? (src < NR) : 1'b0;
        exp_we  = '0;
        exp_oe  = '0;
        exp_bus = '0;
        if (legal) begin
            if (op != 2'd2) exp_we[dst] = 1'b1;
            if (op != 2'd1) exp_oe[src] = 1'b1;
            exp_bus = (op == 2'd1) ? imm : mdl[src];
        end
        bif.i_w_valid = 1'b1;
        bif.i_w_op    = op;
        bif.i_w_src   = AW'(src);
        bif.i_w_dst   = AW'(dst);
        bif.i_w_imm   = imm;
        w = 0;
        while (!bif.o_w_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(bif.o_w_ready), 1);
        if (!bif.o_w_ready) begin
            bif.i_w_valid = 1'b0;
            return;
        end
        if (exp_gap > 0) check("accept_gap", 32'(cyc + 1 - last_acc), 32'(exp_gap));
        last_acc = cyc + 1;
        @(negedge clk);
        if (!hold) bif.i_w_valid = 1'b0;
        if (!legal) begin
            check("rej_error", 32'(bif.o_w_error), 1);
            check("rej_we", 32'(bif.o_w_we), 0);
            check("rej_oe", 32'(bif.o_w_oe), 0);
            check("rej_drive", 32'(dut.drive_q), 0);
            check("rej_ready", 32'(bif.o_w_ready), 1);
            @(negedge clk);
            check("rej_error_once", 32'(bif.o_w_error), 0);
            return;
        end
        check("exec_we", 32'(bif.o_w_we), 32'(exp_we));
        check("exec_oe", 32'(bif.o_w_oe), 32'(exp_oe));
        check("exec_drive", 32'(dut.drive_q), 32'(op == 2'd1));
        check("exec_bus", 32'(bus_w), 32'(exp_bus));
        check("exec_ready", 32'(bif.o_w_ready), 0);
        @(negedge clk);
        check("turn_we", 32'(bif.o_w_we), 0);
        check("turn_oe", 32'(bif.o_w_oe), 0);
        check("turn_drive", 32'(dut.drive_q), 0);
        check("turn_ready", 32'(bif.o_w_ready), 0);
        check("turn_rd_valid", 32'(bif.o_w_rd_valid), 32'(op == 2'd2));
        if (op == 2'd2) last_rd = mdl[src];
        check("rd_data", 32'(bif.o_w_rd_data), 32'(last_rd));
        if (op == 2'd0) mdl[dst] = mdl[src];
        if (op == 2'd1 && !ignore_we) mdl[dst] = imm;
`ifdef BUS_CONTROLLER_READBACK_EN
        if (op == 2'd1) begin
            @(negedge clk);
            check("verify_oe", 32'(bif.o_w_oe), 32'(exp_we));
            check("verify_we", 32'(bif.o_w_we), 0);
            check("verify_ready", 32'(bif.o_w_ready), 0);
            @(negedge clk);
            check("verify_error", 32'(bif.o_w_error), 32'(mdl[dst] != imm));
            check("turn2_oe", 32'(bif.o_w_oe), 0);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        seed = 1'b1;
        ignore_we = 1'b0;
        last_rd = '0;
        bif.i_w_valid = 1'b0;
        bif.i_w_op = 2'd0;
        bif.i_w_src = '0;
        bif.i_w_dst = '0;
        bif.i_w_imm = '0;
        for (int i = 0; i < NR; i++) mdl[i] = DW'(8'h20 + i * 8'h13);
        repeat (3) @(negedge clk);
        check("rst_we", 32'(bif.o_w_we), 0);
        check("rst_oe", 32'(bif.o_w_oe), 0);
        check("rst_drive", 32'(dut.drive_q), 0);
        check("rst_rd_data", 32'(bif.o_w_rd_data), 0);
        check("rst_rd_valid", 32'(bif.o_w_rd_valid), 0);
        check("rst_error", 32'(bif.o_w_error), 0);
        check("rst_ready", 32'(bif.o_w_ready), 1);
        rst_n = 1'b1;
        seed = 1'b0;
        @(negedge clk);

        // Reset asserted in the middle of a LOAD EXEC cycle
        bif.i_w_valid = 1'b1;
        bif.i_w_op = 2'd1;
        bif.i_w_dst = AW'(2);
        bif.i_w_imm = 8'hA5;
        @(negedge clk);
        bif.i_w_valid = 1'b0;
        check("mid_exec_we", 32'(bif.o_w_we), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(bif.o_w_we), 0);
        check("mid_rst_oe", 32'(bif.o_w_oe), 0);
        check("mid_rst_drive", 32'(dut.drive_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bif.o_w_ready), 1);
        check("mid_rst_reg2", 32'(regs[2]), 32'(mdl[2]));

        // LOAD then READ back
        do_cmd(2'd1, 0, 1, 8'h3C, 0, 0);
        do_cmd(2'd2, 1, 0, 8'h00, 0, 0);
        check("load_read_data", 32'(bif.o_w_rd_data), 32'h3C);

        // LOAD, MOVE, READ chain
        do_cmd(2'd1, 0, 0, 8'h11, 0, 0);
        do_cmd(2'd0, 0, 3, 8'h00, 0, 0);
        do_cmd(2'd2, 3, 0, 8'h00, 0, 0);
        check("move_chain_data", 32'(bif.o_w_rd_data), 32'h11);

        // Rejected commands
        do_cmd(2'd0, 2, 2, 8'h00, 0, 0);
        do_cmd(2'd3, 0, 1, 8'h00, 0, 0);
        do_cmd(2'd1, 0, 5, 8'h77, 0, 0);

        // Back-to-back LOADs with valid held
        do_cmd(2'd1, 0, 0, DW'($urandom), 1, 0);
        do_cmd(2'd1, 0, 1, DW'($urandom), 1, LOAD_GAP);
        do_cmd(2'd1, 0, 2, DW'($urandom), 0, LOAD_GAP);

        // Randomized commands
        for (int k = 0; k < 40; k++) begin
            do_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 5)), DW'($urandom), 0, 0);
        end

`ifdef BUS_CONTROLLER_READBACK_EN
        // Register 0 ignores its write enable: VERIFY must flag the mismatch
        do_cmd(2'd1, 0, 0, 8'h00, 0, 0);
        ignore_we = 1'b1;
        do_cmd(2'd1, 0, 0, 8'hFF, 1, 0);
        ignore_we = 1'b0;
        do_cmd(2'd2, 0, 0, 8'h00, 0, 5);
        check("readback_reg0", 32'(bif.o_w_rd_data), 32'h00);
`endif

        @(negedge clk);
        for (int i = 0; i < NR; i++) check("final_reg", 32'(regs[i]), 32'(mdl[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Sequencing master for the shared tri-state data bus that links a bank of bus registers.
- Each register writes on the clock edge when its we=1 and oe=0, and drives the bus when oe=1 and we=0.
- Accepts one transfer command at a time (register-to-register move, load-immediate, read-to-host) and drives one-hot per-register we/oe strobes.
- Drives or samples the bus itself as the operation requires and inserts a turnaround cycle so no two drivers overlap.

Parameters:
p_data_width, 8, bus and register data width
p_num_regs, 4, number of attached registers (size of we/oe vectors)
p_addr_width, 2, width of register index fields; the bench constrains 2**p_addr_width >= p_num_regs

Ports:
i_w_clk  input  1  clock, rising edge active
i_w_reset  input  1  asynchronous, active-low reset
i_w_valid  input  1  command valid
o_w_ready  output  1  controller can accept a command
i_w_op  input  2  00=MOVE src->dst, 01=LOAD imm->dst, 10=READ src->host, 11=illegal
i_w_src  input  p_addr_width  source register index
i_w_dst  input  p_addr_width  destination register index
i_w_imm  input  p_data_width  immediate for LOAD
o_w_we  output  p_num_regs  per-register write enables, at most one bit set
o_w_oe  output  p_num_regs  per-register output enables, at most one bit set
io_w_bus  inout  p_data_width  shared tri-state bus
o_w_rd_data  output  p_data_width  data captured by READ
o_w_rd_valid  output  1  one-cycle pulse when o_w_rd_data is updated
o_w_error  output  1  one-cycle pulse on a rejected command or verify failure

Behaviour:
- Reset (asynchronous, i_w_reset=0):
  - Immediately sets o_w_we=0, o_w_oe=0, bus released to z, o_w_rd_data=0, o_w_rd_valid=0, o_w_error=0.
  - State becomes IDLE.
  - Reset mid-operation aborts the operation with no partial strobe.
- State machine IDLE -> EXEC -> TURN -> IDLE:
  - o_w_ready=1 only in IDLE.
  - A command is accepted on the edge where i_w_valid & o_w_ready. op, src, dst and imm are latched at that edge.
- Command validation at acceptance. The command is rejected if any of these hold:
  - op=11;
  - an index used by the op is >= p_num_regs;
  - MOVE with src==dst (a register with we=oe=1 does nothing).
- A rejected command pulses o_w_error in the next cycle, stays in IDLE, and produces no strobes or bus activity. It is re-accepted no earlier than that cycle's end.
- EXEC lasts exactly one cycle. All strobes and the bus enable are registered (glitch-free).
  - MOVE: o_w_oe[src]=1, o_w_we[dst]=1, controller bus driver = z. The destination captures at the end of EXEC.
  - LOAD: o_w_we[dst]=1, controller drives i_w_imm onto the bus. No oe bit set.
  - READ: o_w_oe[src]=1. The controller samples the bus into o_w_rd_data at the end of EXEC, and o_w_rd_valid pulses during TURN.
- TURN lasts exactly one cycle: all strobes are 0 and the bus is released. It guarantees a driver-free cycle between consecutive operations.
- Throughput and latency:
  - Accept at edge N, EXEC in cycle N+1, TURN in cycle N+2, o_w_ready=1 again in cycle N+3.
  - Back-to-back commands therefore issue every 3 cycles.
- i_w_valid while not ready is ignored (not queued). The host must hold i_w_valid until accepted.
- o_w_rd_data holds its last value until the next READ.
- Invariants checked by the bench:
  - The controller never drives the bus in a cycle where any o_w_oe bit is 1.
  - popcount(o_w_we) <= 1 and popcount(o_w_oe) <= 1.

Optional Feature:
- Macro: BUS_CONTROLLER_READBACK_EN.
- When defined:
  - LOAD inserts a VERIFY state after TURN. VERIFY asserts o_w_oe[dst] for one cycle and compares the bus with the latched imm.
  - On mismatch, o_w_error pulses in the cycle after VERIFY.
  - A second TURN follows VERIFY. LOAD then takes 5 cycles from accept to ready; MOVE and READ timing are unchanged.
- When undefined: no VERIFY state, and LOAD timing is as above.

Test Plan:
- Reset mid-EXEC of LOAD dst=2 imm=8'hA5: all strobes drop to 0 and the bus goes z asynchronously, before the next edge. Register 2 is unchanged, and after reset release o_w_ready=1.
- LOAD dst=1 imm=8'h3C, then READ src=1: we[1] high for one cycle with bus=8'h3C. Then oe[1] high for one cycle, o_w_rd_data=8'h3C, with o_w_rd_valid pulsing 2 cycles after READ acceptance.
- LOAD r0=8'h11, then MOVE src=0 dst=3, then READ src=3: o_w_rd_data=8'h11. During MOVE EXEC, oe=4'b0001 and we=4'b1000 and the controller bus driver is z.
- MOVE src=2 dst=2, then op=11, then LOAD dst=5 (p_num_regs=4): each gives one o_w_error pulse, no strobes, and the state stays IDLE.
- i_w_valid held high with 3 consecutive LOADs: accepts are spaced exactly 3 cycles apart, each EXEC is followed by a cycle with all strobes 0, and the bus is never double-driven.
- BUS_CONTROLLER_READBACK_EN defined, target register model forced to ignore we: LOAD dst=0 imm=8'hFF produces a VERIFY oe[0] cycle, then an o_w_error pulse, and ready is reasserted 5 cycles after accept.
